// File: rtl/par_serial_tx_if.sv
// Parallel word handshake into par_serial_tx: an upstream master presents words,
// and the transmit stage (slave) accepts them into its small buffer.
interface par_serial_tx_if #(
    parameter int WORD_W = 8
);
    // Handshake: a word transfers on a rising clk32f edge where valid_in && ready_out.
    // ready_out depends only on registered state in the slave, never on valid_in.
    // While valid_in is high and ready_out is low, the master must hold data_in stable.
    logic [WORD_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out
    );
endinterface

// File: rtl/par_serial_tx.sv
// Parallel-to-serial transmit stage: COM training after reset, then MSB-first words or COM fillers.
// Optional saturating dropped-write counter on drop_cnt when PAR_SERIAL_DROPCNT_EN is defined.
module par_serial_tx #(
    parameter int                WORD_W   = 8,
    parameter logic [WORD_W-1:0] COM_SYM  = 8'hBC,
    parameter int                SYNC_CNT = 4
) (
    input  logic           clk32f,
    input  logic           reset,
    par_serial_tx_if.slave bus,
    output logic           out,
    output logic           sending_data,
    output logic           sym_start,
    output logic           state_dbg
`ifdef PAR_SERIAL_DROPCNT_EN
    ,
    output logic [7:0]     drop_cnt
`endif
);

    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int SW = (SYNC_CNT > 1) ? $clog2(SYNC_CNT + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);
    localparam logic [SW-1:0] LAST_SYNC = SW'(SYNC_CNT - 1);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] sh_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [SW-1:0]     sync_cnt_q;
    logic              data_flag_q;
    logic              sym_q;

    logic [WORD_W-1:0] fifo_mem [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    logic              boundary;
    logic              ready;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] next_word;

    assign boundary  = (bit_cnt_q == LAST_BIT);
    assign ready     = (state_q == ST_RUN) && (count_q != 2'd2);
    assign push      = bus.valid_in && ready;
    assign pop       = boundary && (state_q == ST_RUN) && (count_q != 2'd0);
    assign next_word = pop ? fifo_mem[rd_ptr_q] : COM_SYM;

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // SYNC leaves only on the boundary that loads the last training COM.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_SYNC && boundary && sync_cnt_q == LAST_SYNC) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            sh_q        <= '0;
            bit_cnt_q   <= LAST_BIT;
            sync_cnt_q  <= '0;
            data_flag_q <= 1'b0;
            sym_q       <= 1'b0;
        end else if (boundary) begin
            sh_q        <= next_word;
            bit_cnt_q   <= '0;
            data_flag_q <= pop;
            sym_q       <= 1'b1;
            if (state_q == ST_SYNC) begin
                sync_cnt_q <= sync_cnt_q + SW'(1);
            end
        end else begin
            sh_q      <= {sh_q[WORD_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            sym_q     <= 1'b0;
        end
    end

    always_ff @(posedge clk32f) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.data_in;
        end
    end

    // A push and a pop on the same edge leave the count alone; pointers keep order.
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef PAR_SERIAL_DROPCNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            drop_q <= 8'd0;
        end else if (state_q == ST_RUN && bus.valid_in && !ready && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

    assign out           = sh_q[WORD_W-1];
    assign sending_data  = data_flag_q;
    assign sym_start     = sym_q;
    assign state_dbg     = (state_q == ST_RUN);
    assign bus.ready_out = ready;

endmodule

// File: tb/tb_par_serial_tx.sv
// Self-checking bench for par_serial_tx: word-level reference model predicting every serial bit.
// Define PAR_SERIAL_DROPCNT_EN in both RTL and bench builds to exercise drop_cnt.
module tb_par_serial_tx;

  localparam int SYNC_CNT = 4;
  localparam logic [7:0] COM = 8'hBC;

  // clock / reset
  logic clk32f = 1'b0;
  logic reset;
  always #5 clk32f = ~clk32f;

  par_serial_tx_if #(.WORD_W(8)) bus ();
  logic out;
  logic sending_data;
  logic sym_start;
  logic state_dbg;
`ifdef PAR_SERIAL_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  par_serial_tx #(
    .WORD_W  (8),
    .COM_SYM (COM),
    .SYNC_CNT(SYNC_CNT)
  ) dut (
    .clk32f      (clk32f),
    .reset       (reset),
    .bus         (bus),
    .out         (out),
    .sending_data(sending_data),
    .sym_start   (sym_start),
    .state_dbg   (state_dbg)
`ifdef PAR_SERIAL_DROPCNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  // reference model: edge index since reset release, words loaded, buffered words
  int         checks = 0;
  int         errors = 0;
  int         edge_n = 0;
  int         loaded = 0;
  int         exp_drops = 0;
  int         data_words = 0;
  logic [7:0] cur = 8'h00;
  logic       cur_data = 1'b0;
  logic       exp_ready = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, advance one edge, compare all outputs.
  task automatic cycle(input logic v, input logic [7:0] d, output logic acc);
    logic run;
    int   pos;
    bus.valid_in = v;
    bus.data_in  = d;
    run       = (loaded >= SYNC_CNT);
    exp_ready = run && (exp_q.size() < 2);
    check("ready_out", {31'd0, bus.ready_out}, {31'd0, exp_ready});
    acc = v && exp_ready;
    if (v && !exp_ready && run && exp_drops < 255) exp_drops++;
    @(posedge clk32f);
    edge_n++;
    if ((edge_n - 1) % 8 == 0) begin
      if (loaded < SYNC_CNT || exp_q.size() == 0) begin
        cur      = COM;
        cur_data = 1'b0;
      end else begin
        cur      = exp_q.pop_front();
        cur_data = 1'b1;
        data_words++;
      end
      loaded++;
    end
    if (acc) exp_q.push_back(d);
    #1;
    pos = (edge_n - 1) % 8;
    check("out", {31'd0, out}, {31'd0, cur[7-pos]});
    check("sending_data", {31'd0, sending_data}, {31'd0, cur_data});
    check("sym_start", {31'd0, sym_start}, {31'd0, (pos == 0)});
    check("state_dbg", {31'd0, state_dbg}, {31'd0, (loaded >= SYNC_CNT)});
`ifdef PAR_SERIAL_DROPCNT_EN
    check("drop_cnt", {24'd0, drop_cnt}, exp_drops);
`endif
  endtask

  // driver tasks
  task automatic reset_dut();
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    check("rst_out", {31'd0, out}, 32'd0);
    check("rst_ready", {31'd0, bus.ready_out}, 32'd0);
    check("rst_sending", {31'd0, sending_data}, 32'd0);
    check("rst_sym", {31'd0, sym_start}, 32'd0);
    check("rst_state", {31'd0, state_dbg}, 32'd0);
`ifdef PAR_SERIAL_DROPCNT_EN
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);
`endif
    exp_q.delete();
    edge_n    = 0;
    loaded    = 0;
    exp_drops = 0;
    cur       = 8'h00;
    cur_data  = 1'b0;
    repeat (2) @(negedge clk32f);
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), acc);
  endtask

  task automatic send_word(input logic [7:0] d);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    do begin
      cycle(1'b1, d, acc);
      tries++;
    end while (!acc && tries < 40);
    check("send_accept", {31'd0, acc}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic       have;
    logic [7:0] pend;
    int         tries;
    int         words_before;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    have         = 1'b0;
    pend         = 8'h00;

    // 1: idle after reset -> pure COM stream, ready from cycle 26
    reset_dut();
    idle(48);

    // 2: single word A5 at edge 26, then COM again
    reset_dut();
    idle(25);
    send_word(8'hA5);
    idle(24);

    // 3: back-to-back 01,02,03 with third held off until the pop at edge 33
    reset_dut();
    idle(25);
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    idle(30);

    // 4: boundary patterns
    send_word(8'hFF);
    send_word(8'h00);
    send_word(8'hBD);
    send_word(8'hBC);
    send_word(8'h3C);
    idle(40);

    // 5: randomized upstream, word held until accepted
    for (int i = 0; i < 400; i++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        pend = 8'($urandom);
        have = 1'b1;
      end
      cycle(have && ($urandom_range(0, 4) != 0), pend, acc);
      if (acc) have = 1'b0;
    end
    bus.valid_in = 1'b0;
    idle(24);

    // 6: reset in the middle of the second data word
    reset_dut();
    idle(25);
    words_before = data_words;
    send_word(8'h5A);
    send_word(8'hF0);
    send_word(8'h77);
    tries = 0;
    while (!(cur_data && cur == 8'hF0 && (edge_n - 1) % 8 == 2) && tries < 40) begin
      cycle(1'b0, 8'h00, acc);
      tries++;
    end
    check("midword_reached", {31'd0, (tries < 40)}, 32'd1);
    check("midword_words", data_words - words_before, 32'd2);
    reset_dut();
    idle(48);

`ifdef PAR_SERIAL_DROPCNT_EN
    // 7: hold valid against a busy buffer until the drop counter saturates
    idle(25);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom), acc);
    check("drop_saturated", {24'd0, drop_cnt}, 32'd255);
    bus.valid_in = 1'b0;
    idle(8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/par_serial_tx.md
# par_serial_tx

Parallel-to-serial transmit stage that drives the serial `in` input of `phy_rx` in the PCIe physical-layer pipeline. It accepts 8-bit words via a valid/ready handshake into a 2-entry buffer and shifts them out MSB-first at one bit per `clk32f` cycle. After reset it sends a fixed train of COM symbols so the receiver can align. Whenever no data word is buffered at a word boundary, it inserts a COM filler.

## Interface
- `WORD_W`, 8: word width; the bit counter is log2(WORD_W) bits.
- `COM_SYM`, 8'hBC: alignment/filler symbol.
- `SYNC_CNT`, 4: number of COM words sent after reset before data is accepted (≥1).

- `clk32f`  in  1  serial bit clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  WORD_W  parallel word to transmit.
- `valid_in`  in  1  `data_in` valid.
- `ready_out`  out  1  buffer can accept a word this cycle.
- `out`  out  1  serial bit stream, MSB first; connects to `phy_rx.in`.
- `sending_data`  out  1  high while `out` carries a bit of a data word (not COM).
- `sym_start`  out  1  high while `out` carries bit 7 of any word.
- `drop_cnt`  out  8  dropped-write counter; present only with `PAR_SERIAL_DROPCNT_EN`.

## Operation
- Registers:
  - `sh[7:0]` shift register; `out = sh[7]`.
  - `bit_cnt[2:0]`.
  - 2-entry FIFO with count 0..2.
  - `sync_cnt`.
  - Word-kind flag.
  - FSM {SYNC, RUN}.
- Reset (async, `reset`=0): `sh`=0, `bit_cnt`=7, FIFO empty, `sync_cnt`=0, state SYNC. Outputs: `out`=0, `ready_out`=0, `sending_data`=0, `sym_start`=0, `drop_cnt`=0.
- Word boundary edge: an edge with `bit_cnt`==7.
  - At a boundary: `bit_cnt`←0 and a new word loads into `sh`.
  - At any other edge: `sh`←{`sh[6:0]`,0} and `bit_cnt`++.
- SYNC state:
  - Each boundary loads `COM_SYM` and increments `sync_cnt`.
  - The boundary that loads the `SYNC_CNT`-th COM moves the state to RUN.
  - `ready_out`=0 throughout.
- RUN state:
  - Each boundary pops the FIFO head into `sh` if count>0 and sets the data flag.
  - If the FIFO is empty, it loads `COM_SYM` and clears the flag.
  - `ready_out` = (count<2), decoded from registered state.
- Write: when `valid_in`&`ready_out` at an edge, `data_in` is pushed.
- Simultaneous push and pop at a boundary: count is unchanged and order is preserved (FIFO). Push at full is impossible because `ready_out`=0.
- `valid_in` while `ready_out`=0: the word is ignored and not buffered; the upstream must hold it.
- FSM never returns to SYNC except via reset.
- Reset mid-word: `out` drops to 0 immediately. Buffered words are discarded and the full COM train restarts.

## Timing
- First boundary is the first edge after `reset` deasserts (edge 1). Boundaries follow at edges 1, 9, 17, …
- With `SYNC_CNT`=4:
  - COM words load at edges 1, 9, 17, 25.
  - `ready_out` rises after edge 25.
  - Earliest data load is at edge 33.
- Latency: a word accepted at edge E appears as its MSB on `out` after the first boundary edge strictly after E, provided it is the FIFO head. The range is 1–8 cycles, plus 8 per word ahead of it.
- `sending_data` and `sym_start` are registered and aligned with `out`; they change only at boundaries or bit edges.
- Sustained throughput: 1 word per 8 cycles. With a continuous upstream, no COM fillers appear between data words.

## Configuration
- `PAR_SERIAL_DROPCNT_EN` defined:
  - Adds the `drop_cnt` port, an 8-bit saturating counter (sticks at 255).
  - Increments at each edge with `valid_in`=1 and `ready_out`=0 while in RUN.
  - Cleared only by reset.
- Undefined: `drop_cnt` port and counter logic are absent; all other behaviour is identical.

## Test plan
- Reset release, `valid_in`=0 for 48 cycles -> `out` = 10111100 repeated 6×, `sym_start` every 8 cycles, `sending_data`=0, `ready_out`=1 from cycle 26.
- Write 8'hA5 at edge 26, then idle -> `out` bits 33–40 = 10100101 with `sending_data`=1, then COM again.
- Back-to-back writes 8'h01, 8'h02, 8'h03 starting edge 26 -> third write held off (`ready_out`=0 until edge 33 pop); serial order 01, 02, 03 with no COM gaps.
- Assert `reset`=0 in the middle of the second data word -> `out`=0 immediately. After release, 4 COM words restart and the buffered data is not sent.
- With `PAR_SERIAL_DROPCNT_EN`, hold `valid_in`=1 while FIFO full for 300 cycles -> `drop_cnt` saturates at 255. A second build without the macro compiles with no `drop_cnt` port.
- Loopback into `phy_rx`, sending 8'hFF, 8'h00, 8'hBC-adjacent patterns -> receiver outputs match the sent words after alignment.
